// File: rtl/haar_pkg.sv
// Shared types and helpers for the Haar cascade stage evaluator.
package haar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACCUM,
    ST_COMPARE,
    ST_DONE
  } state_t;

  // Signed saturation bounds for an accumulator of the given width (width <= 31).
  function automatic int sat_max(int unsigned width);
    return (1 <<< (width - 1)) - 1;
  endfunction

  function automatic int sat_min(int unsigned width);
    return -(1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/haar_sat_accumulator.sv
// Signed saturating accumulator: sign-extends each input and clamps instead of wrapping.
module haar_sat_accumulator
  import haar_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int EXT_W = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH:0] MAX_EXT = EXT_W'(sat_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH:0] MIN_EXT = EXT_W'(sat_min(ACC_WIDTH));

  logic signed [ACC_WIDTH:0] din_ext;
  logic signed [ACC_WIDTH:0] acc_ext;
  logic signed [ACC_WIDTH:0] sum;
  logic        [ACC_WIDTH-1:0] sat;

  // One guard bit is enough: a single add of two in-range values cannot exceed it.
  assign din_ext = {{(EXT_W - DATA_WIDTH){din[DATA_WIDTH-1]}}, din};
  assign acc_ext = {acc[ACC_WIDTH-1], acc};
  assign sum     = acc_ext + din_ext;

  always_comb begin
    sat = sum[ACC_WIDTH-1:0];
    if (sum > MAX_EXT) begin
      sat = MAX_EXT[ACC_WIDTH-1:0];
    end else if (sum < MIN_EXT) begin
      sat = MIN_EXT[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sat;
    end
  end

endmodule

// File: rtl/haar_stage_evaluator.sv
// Walks a Haar cascade stage by stage, accumulating leaf values and rejecting early.
module haar_stage_evaluator
  import haar_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ACC_WIDTH     = 16,
  parameter int STAGE_WIDTH   = 5,
  parameter int FEATURE_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_start,
  input  logic [STAGE_WIDTH-1:0]   i_num_stages,
  input  logic [FEATURE_WIDTH-1:0] i_stage_feature_count,
  input  logic [ACC_WIDTH-1:0]     i_stage_threshold,
  input  logic                     i_haar_valid,
  input  logic [DATA_WIDTH-1:0]    i_haarvalue,
  output logic                     o_haar_ready,
  output logic                     o_busy,
  output logic [STAGE_WIDTH-1:0]   o_stage_index,
  output logic [FEATURE_WIDTH-1:0] o_feature_index,
  output logic                     o_done,
  output logic                     o_face,
  output logic [STAGE_WIDTH-1:0]   o_fail_stage
);

  state_t state, state_nx;

  logic [STAGE_WIDTH-1:0]   num_stages;
  logic [STAGE_WIDTH-1:0]   stage_idx;
  logic [FEATURE_WIDTH-1:0] feat_idx;
  logic [FEATURE_WIDTH-1:0] feat_count;
  logic [ACC_WIDTH-1:0]     threshold;
  logic [ACC_WIDTH-1:0]     acc;
  logic                     face;
  logic [STAGE_WIDTH-1:0]   fail_stage;

  logic handshake;
  logic last_feature;
  logic last_stage;
  logic pass;

  assign handshake    = (state == ST_ACCUM) && i_haar_valid;
  assign last_feature = (feat_idx == feat_count - FEATURE_WIDTH'(1));
  assign last_stage   = (stage_idx == num_stages - STAGE_WIDTH'(1));
  assign pass         = $signed(acc) >= $signed(threshold);

  haar_sat_accumulator #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (state == ST_LOAD),
    .en    (handshake),
    .din   (i_haarvalue),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    o_haar_ready = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_nx = (i_num_stages == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_nx = (i_stage_feature_count == '0) ? ST_COMPARE : ST_ACCUM;
      end
      ST_ACCUM: begin
        o_haar_ready = 1'b1;
        if (handshake && last_feature) begin
          state_nx = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        state_nx = (pass && !last_stage) ? ST_LOAD : ST_DONE;
      end
      ST_DONE: begin
        o_done   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_stages <= '0;
      stage_idx  <= '0;
      feat_idx   <= '0;
      feat_count <= '0;
      threshold  <= '0;
      face       <= 1'b0;
      fail_stage <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            num_stages <= i_num_stages;
            stage_idx  <= '0;
            // An empty cascade is an immediate accept.
            face       <= (i_num_stages == '0);
            fail_stage <= '0;
          end
        end
        ST_LOAD: begin
          feat_count <= i_stage_feature_count;
          threshold  <= i_stage_threshold;
          feat_idx   <= '0;
        end
        ST_ACCUM: begin
          if (handshake) begin
            feat_idx <= feat_idx + FEATURE_WIDTH'(1);
          end
        end
        ST_COMPARE: begin
          if (!pass) begin
            face       <= 1'b0;
            fail_stage <= stage_idx;
          end else if (last_stage) begin
            face       <= 1'b1;
            fail_stage <= '0;
          end else begin
            stage_idx <= stage_idx + STAGE_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_stage_index   = stage_idx;
  assign o_feature_index = feat_idx;
  assign o_face          = face;
  assign o_fail_stage    = fail_stage;

endmodule

// File: doc/haar_stage_evaluator.md
# haar_stage_evaluator

Downstream consumer of the per-feature Haar classifier output. Accumulates the left/right leaf words produced for every feature of a cascade stage, compares the stage sum against the stage threshold, and walks the cascade stage by stage with early rejection. Emits one face/no-face verdict per detection window. Drives stage and feature indices back to the parameter store that feeds the classifier.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one Haar leaf value (signed, two's complement)
- ACC_WIDTH, 16, stage accumulator and stage-threshold width (signed)
- STAGE_WIDTH, 5, stage index/count width
- FEATURE_WIDTH, 8, feature index/count width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  begin evaluation of a new window; honoured only in IDLE
- i_num_stages  in  STAGE_WIDTH  cascade length, sampled on accepted i_start
- i_stage_feature_count  in  FEATURE_WIDTH  features in current stage, sampled in LOAD
- i_stage_threshold  in  ACC_WIDTH  signed stage threshold, sampled in LOAD
- i_haar_valid  in  1  i_haarvalue is valid this cycle
- i_haarvalue  in  DATA_WIDTH  signed leaf value from the classifier
- o_haar_ready  out  1  high only in ACCUM; a value is consumed when valid and ready are both high
- o_busy  out  1  high in every state except IDLE
- o_stage_index  out  STAGE_WIDTH  current stage
- o_feature_index  out  FEATURE_WIDTH  index of the next feature to be accepted
- o_done  out  1  one-cycle pulse; verdict valid
- o_face  out  1  1 = all stages passed; held until next accepted i_start
- o_fail_stage  out  STAGE_WIDTH  rejecting stage when o_face=0; 0 when o_face=1; held

## Operation
- States: IDLE, LOAD, ACCUM, COMPARE, DONE.
- IDLE: i_start=1 latches num_stages, clears stage index, -> LOAD. If latched num_stages=0: -> DONE directly with face=1.
- LOAD: latch feature count and threshold, clear accumulator and feature index. Count=0 -> COMPARE; else -> ACCUM.
- ACCUM: on each handshake, acc <= sat(acc + sign_ext(i_haarvalue)), feature index +1. Handshake on index = count-1 -> COMPARE.
- Saturation: clamp to signed ACC_WIDTH min/max, never wrap.
- COMPARE, pass when acc >= threshold (signed):
  - pass, stage = num_stages-1 -> DONE, face=1, fail_stage=0
  - pass, otherwise -> stage+1 -> LOAD
  - fail -> DONE, face=0, fail_stage=stage
- DONE: o_done=1 for this single cycle -> IDLE.
- i_start outside IDLE is ignored. i_haar_valid outside ACCUM is ignored; nothing is consumed.
- reset_n low at any time, including mid-stage: immediately IDLE, accumulator cleared, all outputs at reset values; no o_done for the aborted window.

## Timing
- Reset values: o_haar_ready=0, o_busy=0, o_done=0, o_face=0, o_fail_stage=0, o_stage_index=0, o_feature_index=0.
- All outputs are registered or decoded from registered state only. No input->output combinational path.
- For i_start accepted at edge 0: LOAD in cycle 1; ACCUM from cycle 2.
- A stage of F features with valid held high costs 1 (LOAD) + F + 1 (COMPARE) cycles.
- o_done is high in the cycle after the final COMPARE.
- Single stage, F=3, no stalls: o_done in cycle 6.
- Deasserting i_haar_valid stalls ACCUM with no loss; the accumulator holds.
- o_stage_index and o_feature_index update on the edge that leaves LOAD or that completes a handshake. The upstream store may use them as a read address one cycle ahead of consumption.

## Structure
- Shared package haar_pkg:
  - state enum typedef (IDLE/LOAD/ACCUM/COMPARE/DONE)
  - signed saturation bounds derived from ACC_WIDTH
- One natural sub-module: haar_sat_accumulator (signed add, sign-extend, saturate, clear, enable).
- FSM and counters stay in the top module.

## Test plan
- Single stage, threshold 10, values 4,4,3 back-to-back -> sum 11, o_done in cycle 6, o_face=1, o_fail_stage=0.
- 3 stages; stage 1 sums to 5 against threshold 6 -> o_face=0, o_fail_stage=1; no LOAD for stage 2; o_busy drops after o_done.
- ACC_WIDTH=8, eight values of +127, threshold 127 -> accumulator saturates at 127, pass. Repeat with -128s against threshold -128 -> pass, no wrap.
- Feature count 0, threshold 0 -> pass without any handshake. Same with threshold 1 -> fail at that stage.
- i_haar_valid toggling 1,0,0,1,1 on a 3-feature stage -> exactly 3 values consumed; o_done delayed by exactly 2 cycles. A second i_start pulsed while busy is ignored.
- reset_n pulsed low mid-ACCUM in stage 2 -> all outputs return to reset values asynchronously, no o_done. A fresh i_start then completes normally.
